pd_event_log: RTL and testbench
===============================

# pd_event_log

Downstream stage of the 4-bit pattern detector. It consumes the detector's `pattern1`/`pattern2` level outputs and converts each new detection into a single event. Each event is counted in a per-pattern saturating counter, tagged with a free-running timestamp, and queued in a small FIFO. A valid/ready port delivers queued events to the host-side consumer.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TS_W`, 12: timestamp width.
- `CNT_W`, 8: per-pattern detection counter width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pattern1`  in  1  detector output, level; high while detector is in its 0531 state.
- `pattern2`  in  1  detector output, level; high while detector is in its 0619 state.
- `clear`  in  1  synchronous: zero counters and `overflow`, flush FIFO.
- `evt_valid`  out  1  FIFO non-empty; `evt_data` holds the head entry.
- `evt_ready`  in  1  consumer accepts the head entry when `evt_valid && evt_ready`.
- `evt_data`  out  2+TS_W (2 without timestamp)  {type[1:0], ts}. Type codes: 01 = p1, 10 = p2, 11 = both.
- `cnt1`  out  CNT_W  pattern1 detections, saturating.
- `cnt2`  out  CNT_W  pattern2 detections, saturating.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Edge detect:
  - `p1_q`/`p2_q` register the previous inputs; reset value 0.
  - `rise1 = pattern1 & ~p1_q`; `rise2 = pattern2 & ~p2_q`.
  - A level held for many cycles (detector enable low) yields exactly one event.
  - A pattern already high in the first cycle after reset counts as a rise.
- Event:
  - An event occurs when `rise1 | rise2`; type = {rise2, rise1}.
  - Simultaneous rises produce one event with type 11.
- Counters:
  - `cnt1` increments on `rise1`; `cnt2` increments on `rise2`.
  - Each holds at 2^CNT_W−1 and does not wrap.
  - Counters increment whether or not the event is queued.
- Timestamp: `ts` increments every cycle; wraps from 2^TS_W−1 to 0. The event carries the `ts` value of the cycle in which the rise is seen.
- FIFO:
  - DEPTH entries; circular read/write pointers plus an occupancy count 0..DEPTH.
  - Push on event when not full, or when full and a pop occurs in the same cycle (pop frees the slot first).
  - Push when full without a pop: event dropped, `overflow` ← 1.
  - Pop on `evt_valid && evt_ready`.
  - Push and pop in the same cycle: occupancy unchanged.
  - The empty FIFO with a push does not bypass; the event is visible the next cycle.
- Output: `evt_valid = (count != 0)`; `evt_data = mem[rd_ptr]`, stable while `evt_valid && !evt_ready`.
- Clear:
  - Zeroes `cnt1`, `cnt2`, `overflow`, pointers and count.
  - An event arising in the same cycle is discarded and not counted.
  - `ts` and edge registers are unaffected.
- Reset: everything zero. `evt_valid`=0, `evt_data`=0, `cnt1`=`cnt2`=0, `overflow`=0, `ts`=0.

## Timing
- Rise at input sampled on edge N → counter updated and entry written at edge N; `evt_valid` high after edge N (observable cycle N+1).
- Pop: handshake at edge M → next entry (or `evt_valid`=0) after edge M.
- Throughput: one event and one pop per cycle sustained.
- Minimum event spacing from the detector is 2 cycles; back-to-back rises on alternate cycles must all queue.
- Reset or clear asserted mid-stream takes effect at the next edge. Entries in flight are lost; no partial output.

## Configuration
- `PD_EVENT_TIMESTAMP_EN`:
  - Defined: `ts` counter built; `evt_data` is 2+TS_W bits, {type, ts}.
  - Undefined: no timestamp counter; `evt_data` is 2 bits (type only); `TS_W` is ignored.
  - Counter, FIFO and handshake behaviour are identical in both builds.

## Test plan
- Reset, hold `pattern1`=1 for 5 cycles starting at ts=10, `evt_ready`=0 → one entry {01, 10}; `cnt1`=1.
- Pulse `pattern2` four times at 2-cycle spacing, then a fifth time, with DEPTH=4 and `evt_ready`=0 → `evt_valid`=1, 4 entries type 10, `overflow`=1, `cnt2`=5.
- FIFO full with `evt_ready`=1 and a rise in the same cycle → event accepted; occupancy stays 4; `overflow` stays 0.
- `pattern1` and `pattern2` rising in the same cycle → single entry type 11; `cnt1`=`cnt2`=1.
- 300 `pattern1` rises with CNT_W=8 → `cnt1`=255; then `clear` together with a rise → `cnt1`=0, FIFO empty, `overflow`=0.
- `PD_EVENT_TIMESTAMP_EN` undefined → `evt_data` is 2 bits wide, and a `pattern2` rise yields `evt_data`=2'b10.

Source files
------------

// File: rtl/pd_event_log.sv
// pd_event_log: turns pattern-detector level outputs into single events,
// counts them per pattern (saturating), and queues them in a small FIFO
// drained through a valid/ready port.
//
// Optional build macro: PD_EVENT_TIMESTAMP_EN
//   defined   -> free-running ts counter built, evt_data = {type[1:0], ts}
//   undefined -> no ts counter, evt_data = type[1:0] only (TS_W ignored)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   pattern1   detector level output (0531 seen)
//   pattern2   detector level output (0619 seen)
//   clear      synchronous: zero counters/overflow, flush FIFO
//   evt_valid  FIFO non-empty
//   evt_ready  consumer accepts head entry
//   evt_data   head entry {type, ts}; type 01=p1, 10=p2, 11=both
//   cnt1/cnt2  saturating per-pattern detection counts
//   overflow   sticky: event dropped on full FIFO
module pd_event_log #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 12,
  parameter int unsigned CNT_W = 8,
`ifdef PD_EVENT_TIMESTAMP_EN
  localparam int unsigned DATA_W = 2 + TS_W
`else
  // TS_W has no effect without the timestamp
  localparam int unsigned DATA_W = 2 + 0 * TS_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pattern1,
  input  logic              pattern2,
  input  logic              clear,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_data,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic              overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef logic [DATA_W-1:0] entry_t;

  logic             p1_q, p2_q;
  logic             rise1, rise2, evt, pop, push, drop, full;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [OCC_W-1:0] occ, occ_n;
  logic [CNT_W-1:0] cnt1_n, cnt2_n;
  logic             overflow_n, valid_n;
  entry_t           mem [DEPTH];
  entry_t           entry, head_n;

`ifdef PD_EVENT_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Free-running timestamp; clear does not touch it
  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  assign entry = {rise2, rise1, ts};
`else
  assign entry = {rise2, rise1};
`endif

  // Edge detect, FIFO control and next-state computation
  always_comb begin
    rise1      = pattern1 & ~p1_q;
    rise2      = pattern2 & ~p2_q;
    evt        = (rise1 | rise2) & ~clear;
    full       = (occ == OCC_W'(DEPTH));
    pop        = evt_valid & evt_ready & ~clear;
    // A pop in the same cycle frees the slot the push needs
    push       = evt & (~full | pop);
    drop       = evt & full & ~pop;

    rd_ptr_n   = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_n   = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    occ_n      = occ;
    if (push && !pop)      occ_n = occ + OCC_W'(1);
    else if (pop && !push) occ_n = occ - OCC_W'(1);

    cnt1_n     = (rise1 && (cnt1 != '1)) ? cnt1 + CNT_W'(1) : cnt1;
    cnt2_n     = (rise2 && (cnt2 != '1)) ? cnt2 + CNT_W'(1) : cnt2;
    overflow_n = overflow | drop;

    if (clear) begin
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
      occ_n      = '0;
      cnt1_n     = '0;
      cnt2_n     = '0;
      overflow_n = 1'b0;
    end

    valid_n = (occ_n != '0);
    // Head is registered, so forward the entry being written into the next head slot
    head_n  = (push && (wr_ptr == rd_ptr_n)) ? entry : mem[rd_ptr_n];
  end

  // State registers, FIFO storage and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      cnt1      <= '0;
      cnt2      <= '0;
      overflow  <= 1'b0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      p1_q      <= pattern1;
      p2_q      <= pattern2;
      if (push) mem[wr_ptr] <= entry;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      occ       <= occ_n;
      cnt1      <= cnt1_n;
      cnt2      <= cnt2_n;
      overflow  <= overflow_n;
      evt_valid <= valid_n;
      evt_data  <= head_n;
    end
  end

endmodule

// File: tb/tb_pd_event_log.sv
// Directed self-checking bench for pd_event_log (DEPTH=4, TS_W=12, CNT_W=8).
// Works in both builds; timestamps are checked when PD_EVENT_TIMESTAMP_EN is defined.
module tb_pd_event_log;

`ifdef PD_EVENT_TIMESTAMP_EN
  localparam int unsigned DW = 14;
`else
  localparam int unsigned DW = 2;
`endif

  logic          clk = 1'b0;
  logic          reset, pattern1, pattern2, clear, evt_ready;
  logic          evt_valid, overflow;
  logic [DW-1:0] evt_data;
  logic [7:0]    cnt1, cnt2;

  int errors = 0;
  int checks = 0;

  logic [11:0] tb_ts;
  logic [11:0] q_ts [8];

  pd_event_log #(.DEPTH(4), .TS_W(12), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .pattern1(pattern1), .pattern2(pattern2),
    .clear(clear), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .cnt1(cnt1), .cnt2(cnt2), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the design's ts holds during the current cycle
  always @(posedge clk) tb_ts <= reset ? 12'd0 : tb_ts + 12'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [1:0] t, input logic [11:0] s);
`ifdef PD_EVENT_TIMESTAMP_EN
    return {18'd0, t, s};
`else
    // type only: shift the timestamp out
    return 32'({t, s}) >> 12;
`endif
  endfunction

  initial begin
    reset = 1'b1; pattern1 = 1'b0; pattern2 = 1'b0; clear = 1'b0; evt_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_data",  32'(evt_data),  32'd0);
    check("rst_cnt1",  32'(cnt1),      32'd0);
    check("rst_cnt2",  32'(cnt2),      32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);

    // Held level at ts=10 gives one event
    for (int i = 0; i < 20 && tb_ts != 12'd10; i++) tick();
    check("ts_reach10", 32'(tb_ts), 32'd10);
    q_ts[0] = tb_ts;
    pattern1 = 1'b1;
    repeat (5) tick();
    pattern1 = 1'b0;
    tick();
    check("hold_valid", 32'(evt_valid), 32'd1);
    check("hold_data",  32'(evt_data),  exp_data(2'b01, q_ts[0]));
    check("hold_cnt1",  32'(cnt1),      32'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("hold_single", 32'(evt_valid), 32'd0);

    // Five pattern2 pulses into a 4-deep FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      q_ts[i] = tb_ts;
      pattern2 = 1'b1; tick();
      pattern2 = 1'b0; tick();
    end
    check("ovf_valid", 32'(evt_valid), 32'd1);
    check("ovf_flag",  32'(overflow),  32'd1);
    check("ovf_cnt2",  32'(cnt2),      32'd5);
    check("ovf_cnt1",  32'(cnt1),      32'd1);
    tick();
    check("ovf_stable", 32'(evt_data), exp_data(2'b10, q_ts[0]));
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_valid", 32'(evt_valid), 32'd1);
      check("ovf_drain_data",  32'(evt_data),  exp_data(2'b10, q_ts[i]));
      tick();
    end
    evt_ready = 1'b0;
    check("ovf_empty", 32'(evt_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_ovf",  32'(overflow), 32'd0);
    check("clr_cnt1", 32'(cnt1),     32'd0);
    check("clr_cnt2", 32'(cnt2),     32'd0);

    // Full FIFO, rise and pop in the same cycle
    for (int i = 0; i < 4; i++) begin
      q_ts[i] = tb_ts;
      pattern1 = 1'b1; tick();
      pattern1 = 1'b0; tick();
    end
    q_ts[4] = tb_ts;
    pattern1 = 1'b1; evt_ready = 1'b1; tick();
    pattern1 = 1'b0; evt_ready = 1'b0;
    check("fullpp_valid", 32'(evt_valid), 32'd1);
    check("fullpp_ovf",   32'(overflow),  32'd0);
    check("fullpp_cnt1",  32'(cnt1),      32'd5);
    evt_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("fullpp_drain_valid", 32'(evt_valid), 32'd1);
      check("fullpp_drain_data",  32'(evt_data),  exp_data(2'b01, q_ts[i]));
      tick();
    end
    evt_ready = 1'b0;
    check("fullpp_empty", 32'(evt_valid), 32'd0);

    // Simultaneous rises
    clear = 1'b1; tick(); clear = 1'b0;
    q_ts[0] = tb_ts;
    pattern1 = 1'b1; pattern2 = 1'b1; tick();
    pattern1 = 1'b0; pattern2 = 1'b0;
    check("both_data", 32'(evt_data), exp_data(2'b11, q_ts[0]));
    check("both_cnt1", 32'(cnt1), 32'd1);
    check("both_cnt2", 32'(cnt2), 32'd1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("both_single", 32'(evt_valid), 32'd0);

    // Saturation, then clear colliding with a rise
    evt_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pattern1 = 1'b1; tick();
      pattern1 = 1'b0; tick();
    end
    evt_ready = 1'b0;
    check("sat_cnt1", 32'(cnt1), 32'd255);
    check("sat_cnt2", 32'(cnt2), 32'd1);
    check("sat_ovf",  32'(overflow), 32'd0);
    pattern1 = 1'b1; pattern2 = 1'b1; clear = 1'b1; tick();
    clear = 1'b0; pattern1 = 1'b0; pattern2 = 1'b0;
    check("clrrise_cnt1",  32'(cnt1),      32'd0);
    check("clrrise_cnt2",  32'(cnt2),      32'd0);
    check("clrrise_valid", 32'(evt_valid), 32'd0);
    check("clrrise_ovf",   32'(overflow),  32'd0);
    tick();
    check("clrrise_after_valid", 32'(evt_valid), 32'd0);
    check("clrrise_after_cnt1",  32'(cnt1),      32'd0);

    // Single pattern2 rise type code; reset mid-stream drops queued entry
    q_ts[0] = tb_ts;
    pattern2 = 1'b1; tick(); pattern2 = 1'b0;
    check("p2_data", 32'(evt_data), exp_data(2'b10, q_ts[0]));
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_valid", 32'(evt_valid), 32'd0);
    check("midrst_cnt2",  32'(cnt2),      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
